// File: rtl/task_nibble_pkg.sv
// ============================================================
// Package : task_nibble_pkg
// Shared widths, FSM states and shifter-select codes for task_nibble_tx.
// Revision: 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

package task_nibble_pkg;

  localparam int NIB_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {IDLE, SEND} tx_state_t;

  typedef enum logic [2:0] {
    SEL_KEEP,
    SEL_ADVANCE,
    SEL_LOAD_HOLD,
    SEL_LOAD_IN,
    SEL_CLEAR
  } shift_sel_t;

endpackage

`default_nettype wire

// File: rtl/task_nibble_tx.sv
// ============================================================
// Module : task_nibble_tx
// Serializes words into 4-bit nibbles; a one-word hold register keeps
// back-to-back words gapless. Optional TASK_NIBBLE_PARITY_EN adds out_nib_par.
// Revision: 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module task_nibble_tx
  import task_nibble_pkg::*;
#(
  parameter int NIBBLES   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     in_task_clk,
  input  logic                     in_task_rst,
  input  logic                     in_word_valid,
  input  logic [NIB_W*NIBBLES-1:0] in_word_data,
  output logic                     out_word_ready,
  output logic                     out_nib_valid,
  output logic [NIB_W-1:0]         out_nib_data,
  output logic                     out_nib_last,
  input  logic                     in_nib_ready,
  output logic                     out_busy,
  output logic [CNT_W-1:0]         out_word_count
`ifdef TASK_NIBBLE_PARITY_EN
  ,
  output logic                     out_nib_par
`endif
);

  localparam int                 c_word_w   = NIB_W * NIBBLES;
  localparam int                 c_idx_w    = $clog2(NIBBLES);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

  tx_state_t             r_state, w_state_nxt;
  logic [c_word_w-1:0]   r_shift, w_shift_nxt;
  logic [c_word_w-1:0]   r_hold, w_hold_nxt;
  logic                  r_hold_valid, w_hold_valid_nxt;
  logic [c_idx_w-1:0]    r_index, w_index_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  shift_sel_t            w_sel;
  logic                  w_word_acc;
  logic                  w_nib_xfer;
  logic                  w_last_xfer;

  task automatic compute_next_shift(
    input  logic [c_word_w-1:0] cur_shift,
    input  logic [c_word_w-1:0] hold,
    input  logic [c_word_w-1:0] in_word,
    input  shift_sel_t          sel,
    output logic [c_word_w-1:0] next_shift
  );
    case (sel)
      SEL_KEEP:      next_shift = cur_shift;
      SEL_ADVANCE:   next_shift = (MSB_FIRST != 0) ? (cur_shift << NIB_W)
                                                   : (cur_shift >> NIB_W);
      SEL_LOAD_HOLD: next_shift = hold;
      SEL_LOAD_IN:   next_shift = in_word;
      default:       next_shift = '0;
    endcase
  endtask

  assign w_word_acc  = in_word_valid && !r_hold_valid;
  assign w_nib_xfer  = (r_state == SEND) && in_nib_ready;
  assign w_last_xfer = w_nib_xfer && (r_index == c_last_idx);

  always_comb begin
    w_state_nxt      = r_state;
    w_sel            = SEL_KEEP;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_index_nxt      = r_index;
    w_count_nxt      = r_count;
    w_shift_nxt      = '0;
    case (r_state)
      IDLE: begin
        if (w_word_acc) begin
          w_sel       = SEL_LOAD_IN;
          w_index_nxt = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_last_xfer) begin
          w_count_nxt = r_count + 8'd1;
          w_index_nxt = '0;
          // A pending hold word always wins; it was accepted earlier.
          if (r_hold_valid) begin
            w_sel            = SEL_LOAD_HOLD;
            w_hold_valid_nxt = 1'b0;
          end else if (w_word_acc) begin
            w_sel = SEL_LOAD_IN;
          end else begin
            w_sel       = SEL_CLEAR;
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_nib_xfer) begin
            w_sel       = SEL_ADVANCE;
            w_index_nxt = r_index + c_idx_w'(1);
          end
          if (w_word_acc) begin
            w_hold_nxt       = in_word_data;
            w_hold_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_sel       = SEL_CLEAR;
        w_state_nxt = IDLE;
      end
    endcase
    compute_next_shift(r_shift, r_hold, in_word_data, w_sel, w_shift_nxt);
  end

  always_ff @(posedge in_task_clk or negedge in_task_rst) begin
    if (!in_task_rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_index      <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_index      <= w_index_nxt;
      r_count      <= w_count_nxt;
    end
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign out_nib_data = r_shift[c_word_w-1 -: NIB_W];
    end else begin : g_lsb_first
      assign out_nib_data = r_shift[NIB_W-1:0];
    end
  endgenerate

  assign out_word_ready = !r_hold_valid;
  assign out_nib_valid  = (r_state == SEND);
  assign out_nib_last   = (r_state == SEND) && (r_index == c_last_idx);
  assign out_busy       = (r_state == SEND) || r_hold_valid;
  assign out_word_count = r_count;

`ifdef TASK_NIBBLE_PARITY_EN
  logic [NIB_W-1:0] w_nib_nxt;
  logic             r_nib_par;

  // Parity is taken from the nibble the shifter will present next cycle.
  assign w_nib_nxt = (MSB_FIRST != 0) ? w_shift_nxt[c_word_w-1 -: NIB_W]
                                      : w_shift_nxt[NIB_W-1:0];

  always_ff @(posedge in_task_clk or negedge in_task_rst) begin
    if (!in_task_rst) begin
      r_nib_par <= 1'b1;
    end else begin
      r_nib_par <= ~^w_nib_nxt;
    end
  end

  assign out_nib_par = r_nib_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_task_nibble_tx.sv
// ============================================================
// Module : tb_task_nibble_tx
// Self-checking bench: MSB-first and LSB-first instances against a word-queue model.
// Revision: 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_task_nibble_tx;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wv = 1'b0;
  logic [W-1:0] wd = '0;
  logic         nr = 1'b0;

  logic       m_ready, m_valid, m_last, m_busy;
  logic [3:0] m_data;
  logic [7:0] m_cnt;
  logic       l_ready, l_valid, l_last, l_busy;
  logic [3:0] l_data;
  logic [7:0] l_cnt;
`ifdef TASK_NIBBLE_PARITY_EN
  logic       m_par, l_par;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  task_nibble_tx #(.NIBBLES(N), .MSB_FIRST(1)) dut_msb (
    .in_task_clk   (clk),
    .in_task_rst   (rst_n),
    .in_word_valid (wv),
    .in_word_data  (wd),
    .out_word_ready(m_ready),
    .out_nib_valid (m_valid),
    .out_nib_data  (m_data),
    .out_nib_last  (m_last),
    .in_nib_ready  (nr),
    .out_busy      (m_busy),
    .out_word_count(m_cnt)
`ifdef TASK_NIBBLE_PARITY_EN
    , .out_nib_par (m_par)
`endif
  );

  task_nibble_tx #(.NIBBLES(N), .MSB_FIRST(0)) dut_lsb (
    .in_task_clk   (clk),
    .in_task_rst   (rst_n),
    .in_word_valid (wv),
    .in_word_data  (wd),
    .out_word_ready(l_ready),
    .out_nib_valid (l_valid),
    .out_nib_data  (l_data),
    .out_nib_last  (l_last),
    .in_nib_ready  (nr),
    .out_busy      (l_busy),
    .out_word_count(l_cnt)
`ifdef TASK_NIBBLE_PARITY_EN
    , .out_nib_par (l_par)
`endif
  );

  // Reference model: words in flight (shifter + hold) and nibbles already sent of the head.
  logic [W-1:0] q[$];
  int           sent = 0;
  int           done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] nib_of(input logic [W-1:0] w, input int idx, input bit msb);
    int           pos;
    logic [W-1:0] t;
    pos = msb ? (N - 1 - idx) : idx;
    t   = w >> (4 * pos);
    return t[3:0];
  endfunction

  task automatic model_edge();
    bit acc, xfer;
    acc  = wv && (q.size() < 2);
    xfer = (q.size() > 0) && nr;
    if (xfer) begin
      sent++;
      if (sent == N) begin
        void'(q.pop_front());
        sent     = 0;
        done_cnt = (done_cnt + 1) % 256;
      end
    end
    if (acc) q.push_back(wd);
  endtask

  task automatic check_all();
    bit e_valid, e_last;
    e_valid = (q.size() > 0);
    e_last  = e_valid && (sent == N - 1);
    check_eq("msb_ready", m_ready, q.size() < 2);
    check_eq("lsb_ready", l_ready, q.size() < 2);
    check_eq("msb_valid", m_valid, e_valid);
    check_eq("lsb_valid", l_valid, e_valid);
    check_eq("msb_busy",  m_busy,  e_valid);
    check_eq("lsb_busy",  l_busy,  e_valid);
    check_eq("msb_last",  m_last,  e_last);
    check_eq("lsb_last",  l_last,  e_last);
    check_eq("msb_count", m_cnt,   done_cnt);
    check_eq("lsb_count", l_cnt,   done_cnt);
    if (e_valid) begin
      check_eq("msb_data", m_data, nib_of(q[0], sent, 1'b1));
      check_eq("lsb_data", l_data, nib_of(q[0], sent, 1'b0));
`ifdef TASK_NIBBLE_PARITY_EN
      check_eq("msb_par", m_par, ~^nib_of(q[0], sent, 1'b1));
      check_eq("lsb_par", l_par, ~^nib_of(q[0], sent, 1'b0));
`endif
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_msb_ready"}, m_ready, 1);
    check_eq({tag, "_lsb_ready"}, l_ready, 1);
    check_eq({tag, "_msb_valid"}, m_valid, 0);
    check_eq({tag, "_lsb_valid"}, l_valid, 0);
    check_eq({tag, "_msb_data"},  m_data,  0);
    check_eq({tag, "_lsb_data"},  l_data,  0);
    check_eq({tag, "_msb_last"},  m_last,  0);
    check_eq({tag, "_msb_busy"},  m_busy,  0);
    check_eq({tag, "_lsb_busy"},  l_busy,  0);
    check_eq({tag, "_msb_count"}, m_cnt,   0);
    check_eq({tag, "_lsb_count"}, l_cnt,   0);
`ifdef TASK_NIBBLE_PARITY_EN
    check_eq({tag, "_msb_par"},   m_par,   1);
    check_eq({tag, "_lsb_par"},   l_par,   1);
`endif
  endtask

  // Entered and left at a falling edge; outputs are checked there.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    wv = v;
    wd = d;
    nr = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asserts reset between edges to show it acts without a clock.
  task automatic async_reset(input string tag);
    wv = 1'b0;
    nr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    sent     = 0;
    done_cnt = 0;
    check_reset_vals(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] seq_m[4]  = '{4'hA, 4'h5, 4'hC, 4'h3};
  logic [3:0] seq_l[4]  = '{4'h3, 4'hC, 4'h5, 4'hA};
  logic [3:0] b2b_m[8]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
  logic [3:0] b2b_l[8]  = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0);
    check_reset_vals("idle");

    // Single word, first nibble appears the cycle after acceptance.
    cycle(1'b1, 16'hA5C3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("single_msb_nib", m_data, seq_m[i]);
      check_eq("single_lsb_nib", l_data, seq_l[i]);
      check_eq("single_last",    m_last, (i == 3));
      cycle(1'b0, '0, 1'b1);
    end
    check_eq("single_count", m_cnt, 1);
    check_eq("single_done_valid", m_valid, 0);

    // Back-to-back words, second goes through the hold register.
    cycle(1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) cycle(1'b1, 16'h5678, 1'b1);
      else if (i > 1) cycle(1'b0, '0, 1'b1);
      check_eq("b2b_msb_nib", m_data, b2b_m[i]);
      check_eq("b2b_lsb_nib", l_data, b2b_l[i]);
      check_eq("b2b_valid",   m_valid, 1);
      if (i >= 1 && i <= 3) check_eq("b2b_hold_full_ready", m_ready, 0);
    end
    cycle(1'b0, '0, 1'b1);
    check_eq("b2b_count", m_cnt, 3);

    // Downstream stall on the second nibble.
    cycle(1'b1, 16'hA5C3, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0);
      check_eq("stall_msb_nib", m_data, 4'h5);
      check_eq("stall_valid",   m_valid, 1);
    end
    repeat (4) cycle(1'b0, '0, 1'b1);
    check_eq("stall_count", m_cnt, 4);

    // Reset mid-word with the hold register also full.
    cycle(1'b1, 16'hA5C3, 1'b1);
    cycle(1'b1, 16'h1234, 1'b1);
    async_reset("midword");
    repeat (2) cycle(1'b0, '0, 1'b1);
    check_reset_vals("post_rst");

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 6));

    // Saturated traffic long enough for the word counter to wrap.
    for (int i = 0; i < 1100; i++)
      cycle(1'b1, W'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
